// File: rtl/mac_chain_ctrl_pkg.sv
// Shared types and sizing for the MAC chain controller.
// Used by mac_chain_ctrl and en_skew via import mac_ctrl_pkg::*.
package mac_ctrl_pkg;

    localparam int DEFAULT_N          = 8;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int PERF_CYC_W         = 32;
    localparam int PERF_PASS_W        = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        CLEAR     = 3'd2,
        FILL      = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/mac_chain_ctrl_en_skew.sv
// N-deep enable delay line: en_o[k] is en_i delayed k cycles, mirroring the
// one-cycle en_out hop of each MAC stage. flush_i clears the line synchronously.
module en_skew
    import mac_ctrl_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         en_i,
    output logic [N-1:0] en_o
);

    logic [N-2:0] line_q;

    assign en_o = {line_q, en_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else if (flush_i) begin
            line_q <= '0;
        end else begin
            line_q <= en_o[N-2:0];
        end
    end

endmodule

// File: rtl/mac_chain_ctrl.sv
// Sequencer for an N-stage systolic MAC chain doing one matrix-vector pass.
// Optional perf counters are built only when MAC_CHAIN_CTRL_PERF_EN is defined.
module mac_chain_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int N          = DEFAULT_N
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   fifo_ready,
    output logic                   mac_clr,
    output logic                   mac_en,
    output logic                   b_rd_en,
    output logic [N-1:0]           a_rd_en,
    output logic                   busy,
    output logic                   done,
    output logic [PERF_CYC_W-1:0]  perf_cycles,
    output logic [PERF_PASS_W-1:0] perf_passes
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] FILL_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 2);

    if (N < 2 || N > 64 || DATA_WIDTH < 1) begin : g_bad_cfg
        $error("mac_chain_ctrl: N must be 2..64 and DATA_WIDTH >= 1");
    end

    ctrl_state_t   state_q;
    logic [CW-1:0] cnt_q;
    logic          mac_clr_q;
    logic          mac_en_q;
    logic          b_rd_en_q;
    logic          done_q;
    logic          flush;

    assign busy    = (state_q != IDLE);
    assign flush   = abort && busy;
    assign mac_clr = mac_clr_q;
    assign mac_en  = mac_en_q;
    assign b_rd_en = b_rd_en_q;
    assign done    = done_q;

    // Strobes are pulses: every cycle they default low and only the
    // transition into the state that owns them raises them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mac_clr_q <= 1'b0;
            mac_en_q  <= 1'b0;
            b_rd_en_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            mac_clr_q <= 1'b0;
            mac_en_q  <= 1'b0;
            b_rd_en_q <= 1'b0;
            done_q    <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && !abort) begin
                            if (fifo_ready) begin
                                state_q   <= CLEAR;
                                mac_clr_q <= 1'b1;
                            end else begin
                                state_q <= WAIT_DATA;
                            end
                        end
                    end
                    WAIT_DATA: begin
                        if (fifo_ready) begin
                            state_q   <= CLEAR;
                            mac_clr_q <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        state_q   <= FILL;
                        cnt_q     <= '0;
                        mac_en_q  <= 1'b1;
                        b_rd_en_q <= 1'b1;
                    end
                    FILL: begin
                        if (cnt_q == FILL_LAST) begin
                            state_q <= DRAIN;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q     <= cnt_q + 1'b1;
                            mac_en_q  <= 1'b1;
                            b_rd_en_q <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (cnt_q == DRAIN_LAST) begin
                            state_q <= DONE;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    en_skew #(.N(N)) u_en_skew (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .en_i    (mac_en_q),
        .en_o    (a_rd_en)
    );

`ifdef MAC_CHAIN_CTRL_PERF_EN
    logic                   accept;
    logic [PERF_CYC_W-1:0]  cyc_q;
    logic [PERF_CYC_W-1:0]  cyc_d;
    logic [PERF_CYC_W-1:0]  perf_cycles_q;
    logic [PERF_PASS_W-1:0] perf_passes_q;
    logic [PERF_PASS_W-1:0] perf_passes_d;

    assign accept        = (state_q == IDLE) && start && !abort;
    assign cyc_d         = cyc_q + 1'b1;
    assign perf_passes_d = (&perf_passes_q) ? perf_passes_q : perf_passes_q + 1'b1;
    assign perf_cycles   = perf_cycles_q;
    assign perf_passes   = perf_passes_q;

    // cyc_q holds the cycles already elapsed since acceptance, so the DONE
    // cycle itself is added when the result is latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q         <= '0;
            perf_cycles_q <= '0;
            perf_passes_q <= '0;
        end else begin
            if (accept) begin
                cyc_q <= PERF_CYC_W'(1);
            end else if (busy) begin
                cyc_q <= cyc_d;
            end
            if (state_q == DONE && !abort) begin
                perf_cycles_q <= cyc_d;
                perf_passes_q <= perf_passes_d;
            end
        end
    end
`else
    assign perf_cycles = '0;
    assign perf_passes = '0;
`endif

endmodule

// File: tb/tb_mac_chain_ctrl.sv
// Directed self-checking bench for mac_chain_ctrl (N=8) with a small MAC
// chain model fed by identity A and B=1..8.
module tb_mac_chain_ctrl;

    localparam int N = 8;
`ifdef MAC_CHAIN_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          fifo_ready;
    logic          mac_clr;
    logic          mac_en;
    logic          b_rd_en;
    logic [N-1:0]  a_rd_en;
    logic          busy;
    logic          done;
    logic [31:0]   perf_cycles;
    logic [15:0]   perf_passes;

    int checks = 0;
    int errors = 0;
    int done_total = 0;
    int passes_exp = 0;
    int acc [N];
    int ia  [N];

    always #5 clk = ~clk;

    mac_chain_ctrl #(.DATA_WIDTH(8), .N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .fifo_ready  (fifo_ready),
        .mac_clr     (mac_clr),
        .mac_en      (mac_en),
        .b_rd_en     (b_rd_en),
        .a_rd_en     (a_rd_en),
        .busy        (busy),
        .done        (done),
        .perf_cycles (perf_cycles),
        .perf_passes (perf_passes)
    );

    // MAC k pops row k of A (identity) while its skewed enable is high and
    // multiplies by the matching B element (B[j] = j+1).
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (mac_clr) begin
                acc[k] <= 0;
                ia[k]  <= 0;
            end else if (a_rd_en[k]) begin
                acc[k] <= acc[k] + ((ia[k] == k) ? (ia[k] + 1) : 0);
                ia[k]  <= ia[k] + 1;
            end
        end
        if (done === 1'b1) done_total <= done_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("clr_done_excl", 32'(done & mac_clr), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clr"}, 32'(mac_clr), 32'd0);
        check({tag, "_en"}, 32'(mac_en), 32'd0);
        check({tag, "_brd"}, 32'(b_rd_en), 32'd0);
        check({tag, "_ard"}, 32'(a_rd_en), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic check_perf(input string tag, input int cyc_exp);
        check({tag, "_pcyc"}, perf_cycles, PERF ? 32'(cyc_exp) : 32'd0);
        check({tag, "_ppas"}, 32'(perf_passes), PERF ? 32'(passes_exp) : 32'd0);
    endtask

    // Full pass from cycle 0 with fifo_ready high; checks every output by cycle.
    task automatic full_pass(input string tag);
        logic [N-1:0] exp_a;
        int d0;
        d0 = done_total;
        fifo_ready = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            start = 1'b0;
            for (int k = 0; k < N; k++) exp_a[k] = (c >= 2 + k) && (c <= 9 + k);
            check({tag, "_clr"}, 32'(mac_clr), 32'(c == 1));
            check({tag, "_en"}, 32'(mac_en), 32'(c >= 2 && c <= 9));
            check({tag, "_brd"}, 32'(b_rd_en), 32'(c >= 2 && c <= 9));
            check({tag, "_ard"}, 32'(a_rd_en), 32'(exp_a));
            check({tag, "_done"}, 32'(done), 32'(c == 17));
            check({tag, "_busy"}, 32'(busy), 32'(c <= 17));
            if (c == 17) begin
                for (int k = 0; k < N; k++) check({tag, "_acc"}, 32'(acc[k]), 32'(k + 1));
            end
        end
        passes_exp++;
        check({tag, "_ndone"}, 32'(done_total - d0), 32'd1);
        check_perf(tag, 18);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        fifo_ready = 1'b0;
        #12;
        check_all_zero("reset");
        check_perf("reset", 0);
        rst_n = 1'b1;
        tick();
        tick();

        // Nominal pass
        full_pass("pass1");

        // Data not ready for 5 cycles: WAIT_DATA 1..5, CLEAR 6, done 22
        d0 = done_total;
        fifo_ready = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            tick();
            start = 1'b0;
            if (c == 5) fifo_ready = 1'b1;
            check("wait_clr", 32'(mac_clr), 32'(c == 6));
            check("wait_done", 32'(done), 32'(c == 22));
            check("wait_busy", 32'(busy), 32'(c <= 22));
        end
        passes_exp++;
        check("wait_ndone", 32'(done_total - d0), 32'd1);
        check_perf("wait", 23);

        // Abort in the 3rd FILL cycle (cycle 4)
        d0 = done_total;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("abort_ard_pre", 32'(a_rd_en), 32'h7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_all_zero("abort_post");
        for (int c = 0; c < 20; c++) begin
            tick();
            check("abort_quiet", 32'({a_rd_en, mac_en, b_rd_en, busy}), 32'd0);
        end
        check("abort_ndone", 32'(done_total - d0), 32'd0);
        check_perf("abort", 23);

        // start pulsed during DRAIN is ignored
        d0 = done_total;
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            start = (c == 12);
            check("drain_done", 32'(done), 32'(c == 17));
        end
        start = 1'b0;
        passes_exp++;
        check("drain_ndone", 32'(done_total - d0), 32'd1);
        check_perf("drain", 18);

        // abort with start in IDLE: abort wins; abort alone in IDLE is harmless
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        check_all_zero("abort_start");
        tick();
        abort = 1'b0;
        check_all_zero("abort_idle");

        // Reset asserted in cycle 6 of a pass
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start = 1'b0;
        end
        check("rst_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        passes_exp = 0;
        check_all_zero("rst_mid");
        check_perf("rst_mid", 0);
        tick();
        rst_n = 1'b1;
        tick();
        full_pass("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
